// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, opcodes, instruction fields and FSM states for smallCALC
package calc_pkg;
  localparam int W = 3;
  localparam int NREG = 4;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RD_HI = 5;
  localparam int RD_LO = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;
endpackage

// File: rtl/calc_rf.sv
// calc_rf: NREG x W register file, one sync write port, two operand reads and a debug read
module calc_rf #(
  parameter int W = calc_pkg::W,
  parameter int NREG = calc_pkg::NREG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   ra1,
  output logic [W-1:0] rd1,
  input  logic [1:0]   ra2,
  output logic [W-1:0] rd2,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);
  logic [W-1:0] rf_q [NREG];
  logic [W-1:0] rf_d [NREG];
  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rf_q <= '{default: '0};
    else rf_q <= rf_d;
  end
  assign rd1 = rf_q[ra1];
  assign rd2 = rf_q[ra2];
  assign dbg_data = rf_q[dbg_addr];
endmodule

// File: rtl/calc_seq.sv
// calc_seq: smallCALC instruction sequencer driving an external ALU (IDLE -> ISSUE -> WB)
module calc_seq #(
  parameter int W = calc_pkg::W,
  parameter int NREG = calc_pkg::NREG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [7:0]   instr,
  input  logic         ld_en,
  input  logic [1:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [1:0]   alu_c,
  input  logic [W-1:0] alu_out,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);
  import calc_pkg::*;
  state_e state_q, state_d;
  logic [1:0] rd_q, rd_d, c_q, c_d;
  logic [W-1:0] in1_q, in1_d, in2_q, in2_d, result_q, result_d;
  logic zero_q, zero_d;
  logic accept, ld_take, we, in_issue;
  logic [1:0] rs1, rs2, waddr;
  logic [W-1:0] rd1, rd2, op1, op2, wdata;
  assign rs1 = instr[RS1_HI:RS1_LO];
  assign rs2 = instr[RS2_HI:RS2_LO];
  assign in_issue = state_q == ISSUE;
  assign instr_ready = state_q == IDLE;
  assign accept = instr_valid & instr_ready;
  assign ld_take = ld_en & instr_ready;
  // a load landing in the accept cycle must be seen by the captured operands
  assign op1 = (ld_take && ld_addr == rs1) ? ld_data : rd1;
  assign op2 = (ld_take && ld_addr == rs2) ? ld_data : rd2;
  assign we = in_issue | ld_take;
  assign waddr = in_issue ? rd_q : ld_addr;
  assign wdata = in_issue ? alu_out : ld_data;
  calc_rf #(.W(W), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra1(rs1), .rd1(rd1), .ra2(rs2), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always_comb begin
    state_d = state_q == IDLE ? (accept ? ISSUE : IDLE) : state_q == ISSUE ? WB : IDLE;
    rd_d = accept ? instr[RD_HI:RD_LO] : rd_q;
    in1_d = accept ? op1 : in1_q;
    in2_d = accept ? op2 : in2_q;
    c_d = accept ? instr[OP_HI:OP_LO] : c_q;
    result_d = in_issue ? alu_out : result_q;
    zero_d = in_issue ? (alu_out == '0) : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      c_q <= '0;
      result_q <= '0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      c_q <= c_d;
      result_q <= result_d;
      zero_q <= zero_d;
    end
  end
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;
  assign alu_c = c_q;
  assign result = result_q;
  assign zero = zero_q;
  assign done = state_q == WB;
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed table-driven bench for calc_seq with a behavioural ALU attached
module tb_calc_seq;
  import calc_pkg::*;
  logic clk = 0, rst = 1;
  logic instr_valid = 0, instr_ready, ld_en = 0, done, zero;
  logic [7:0] instr = 0;
  logic [1:0] ld_addr = 0, alu_c, dbg_addr = 0;
  logic [W-1:0] ld_data = 0, alu_in1, alu_in2, alu_out, result, dbg_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  always_comb
    case (alu_c)
      OP_ADD: alu_out = alu_in1 + alu_in2;
      OP_SUB: alu_out = alu_in1 - alu_in2;
      OP_AND: alu_out = alu_in1 & alu_in2;
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
  calc_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c(alu_c), .alu_out(alu_out),
    .done(done), .result(result), .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 0;
  endtask
  task automatic run(input logic [7:0] i, input logic ld, input logic [1:0] la, input logic [W-1:0] ldd,
                     input logic [W-1:0] e1, input logic [W-1:0] e2, input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    instr = i; instr_valid = 1;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    @(negedge clk);
    instr_valid = 0; ld_en = 0;
    check("issue_in1", 8'(alu_in1), 8'(e1));
    check("issue_in2", 8'(alu_in2), 8'(e2));
    check("issue_c", 8'(alu_c), 8'(i[7:6]));
    check("issue_ready", 8'(instr_ready), 8'd0);
    check("issue_done", 8'(done), 8'd0);
    @(negedge clk);
    dbg_addr = i[5:4];
    #1;
    check("wb_done", 8'(done), 8'd1);
    check("wb_result", 8'(result), 8'(er));
    check("wb_zero", 8'(zero), 8'(ez));
    check("wb_dbg_rd", 8'(dbg_data), 8'(er));
    @(negedge clk);
    check("idle_ready", 8'(instr_ready), 8'd1);
    check("idle_done", 8'(done), 8'd0);
  endtask
  typedef struct {
    logic [7:0] i;
    logic [W-1:0] e1, e2, er;
    logic ez;
  } vec_t;
  initial begin
    vec_t tbl[4];
    int acc, dn, dc[3];
    tbl[0] = '{8'h21, 3'd5, 3'd3, 3'd0, 1'b1};
    tbl[1] = '{8'h74, 3'd3, 3'd5, 3'd6, 1'b0};
    tbl[2] = '{8'hA1, 3'd5, 3'd3, 3'd1, 1'b0};
    tbl[3] = '{8'hE1, 3'd5, 3'd3, 3'd6, 1'b0};
    @(negedge clk);
    check("rst_ready", 8'(instr_ready), 8'd1);
    check("rst_done", 8'(done), 8'd0);
    check("rst_zero", 8'(zero), 8'd1);
    check("rst_result", 8'(result), 8'd0);
    check("rst_in1", 8'(alu_in1), 8'd0);
    @(negedge clk);
    rst = 0;
    load(2'd0, 3'd5);
    load(2'd1, 3'd3);
    for (int k = 0; k < 4; k++) run(tbl[k].i, 0, 0, 0, tbl[k].e1, tbl[k].e2, tbl[k].er, tbl[k].ez);
    run(8'h20, 1, 2'd0, 3'd2, 3'd2, 3'd2, 3'd4, 1'b0);
    dbg_addr = 0; #1;
    check("fwd_r0", 8'(dbg_data), 8'd2);
    // held-valid XOR r3,r0,r1 with loads attempted while busy
    @(negedge clk);
    instr = 8'hF1; instr_valid = 1;
    acc = 0; dn = 0;
    for (int k = 0; k < 9; k++) begin
      ld_en = (k == 1 || k == 2); ld_addr = 0; ld_data = 3'd7;
      #1;
      if (instr_valid && instr_ready) acc++;
      if (done) begin
        if (dn < 3) dc[dn] = k;
        dn++;
      end
      @(negedge clk);
    end
    instr_valid = 0; ld_en = 0;
    check("bp_accepts", 8'(acc), 8'd3);
    check("bp_dones", 8'(dn), 8'd3);
    if (dn == 3) begin
      check("bp_space1", 8'(dc[1] - dc[0]), 8'd3);
      check("bp_space2", 8'(dc[2] - dc[1]), 8'd3);
    end
    dbg_addr = 0; #1;
    check("bp_r0_kept", 8'(dbg_data), 8'd2);
    dbg_addr = 3; #1;
    check("bp_r3", 8'(dbg_data), 8'd1);
    @(negedge clk);
    instr = 8'h21; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    rst = 1;
    #1;
    check("arst_ready", 8'(instr_ready), 8'd1);
    check("arst_zero", 8'(zero), 8'd1);
    check("arst_result", 8'(result), 8'd0);
    check("arst_in1", 8'(alu_in1), 8'd0);
    check("arst_c", 8'(alu_c), 8'd0);
    dn = 0;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      dn += int'(done);
      @(negedge clk);
    end
    check("arst_no_done", 8'(dn), 8'd0);
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 2'(k); #1;
      check("arst_rf", 8'(dbg_data), 8'd0);
    end
    load(2'd1, 3'd7);
    run(8'h15, 0, 0, 0, 3'd7, 3'd7, 3'd6, 1'b0);
    run(8'h15, 0, 0, 0, 3'd6, 3'd6, 3'd4, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Instruction sequencer for the smallCALC datapath; the initiator side of the ALU interface.
- Holds a small register file, accepts 8-bit instructions over a valid/ready handshake, and drives operands and opcode to the external ALU.
- Captures the ALU result a fixed cycle later, writes it back, and reports done, result and zero flag.
- Has an operand load port and a combinational debug read port.

Parameters:
- W, 3, data width; must match the ALU in1/in2/aluout width.
- NREG, 4, number of registers; fixed at 4 so the 2-bit address fields in instr are exact.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction or load.
- instr  in  8  fields: [7:6] op (00 add, 01 sub, 10 and, 11 xor), [5:4] rd, [3:2] rs1, [1:0] rs2.
- ld_en  in  1  register load request.
- ld_addr  in  2  register to load.
- ld_data  in  W  load value.
- alu_in1  out  W  ALU operand 1, registered.
- alu_in2  out  W  ALU operand 2, registered.
- alu_c  out  2  ALU opcode, registered.
- alu_out  in  W  ALU result (combinational from alu_in1/alu_in2/alu_c).
- done  out  1  one-cycle pulse: result written back.
- result  out  W  last written-back value.
- zero  out  1  result == 0, updated with result.
- dbg_addr  in  2  debug read address.
- dbg_data  out  W  rf[dbg_addr], combinational.

Behaviour:
- Reset: state IDLE; rf all 0; alu_in1, alu_in2, alu_c, result = 0; zero = 1; done = 0; instr_ready = 1.
- FSM states: IDLE -> ISSUE -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - Accept edge = instr_valid & instr_ready. On it: latch rd, and load alu_in1 <= rf[rs1], alu_in2 <= rf[rs2], alu_c <= op. Go to ISSUE.
- ISSUE:
  - instr_ready = 0; ALU inputs stable.
  - At the end of the cycle: rf[rd] <= alu_out, result <= alu_out, zero <= (alu_out == 0), done <= 1. Go to WB.
- WB:
  - instr_ready = 0; done = 1 for this cycle only. Go to IDLE.
- Latency and throughput:
  - Accept at edge T: done high during cycle T+2; the new rf value is visible on dbg_data from T+2.
  - instr_ready returns high at T+3, so at most one instruction per 3 cycles.
- ALU outputs hold their last values outside ISSUE; they change only on an accept edge.
- Load port:
  - ld_en is honoured only when instr_ready = 1; it writes rf[ld_addr] <= ld_data.
  - ld_en while instr_ready = 0 is dropped, with no other effect.
- Simultaneous load and accept in the same IDLE cycle:
  - The load is performed.
  - If ld_addr equals rs1 and/or rs2, ld_data is forwarded into alu_in1/alu_in2 (new value used, not the old one).
- Arithmetic:
  - Modulo 2^W wrap; no carry or borrow output.
  - The sequencer does not compute results itself; it trusts alu_out.
- rd == rs1 or rs2: allowed. Operands were already captured, so writeback is unambiguous.
- instr_valid held high through ISSUE/WB: not accepted again until IDLE. Each accept executes exactly once.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - The in-flight instruction is discarded: no writeback, no done.

Decomposition:
- Shared package calc_pkg:
  - W, NREG.
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11.
  - Instruction field bit positions.
  - State encoding IDLE/ISSUE/WB.
- One natural sub-module: calc_rf (4 x W register file).
  - One synchronous write port, muxed between load and writeback; they never collide because load is only taken in IDLE.
  - Two combinational operand read ports plus the debug read port.
- Top level instantiates calc_rf and the FSM. The bench connects the existing ALU to alu_in1/alu_in2/alu_c/alu_out.

Test Plan:
- Load sequence: load r0=5, r1=3, then ADD r2,r0,r1 -> done at accept+2, result=0, zero=1, dbg r2=0.
- Other opcodes with r0=5, r1=3:
  - SUB r3,r1,r0 -> result=6, zero=0.
  - AND r2,r0,r1 -> 1.
  - XOR r2,r0,r1 -> 6.
  - alu_c matches the op field for each.
- Forwarding: in the same cycle as accepting ADD r2,r0,r0, load r0=2 (previously 5) -> alu_in1=alu_in2=2, result=4.
- Backpressure: instr_valid held high for 9 cycles with the same instruction -> exactly 3 accepts, 3 done pulses spaced 3 cycles apart. ld_en during ISSUE/WB leaves rf unchanged.
- Reset in ISSUE:
  - Assert rst one cycle after accept -> done never pulses.
  - rf all 0, zero=1, instr_ready=1 immediately (asynchronous).
  - Next instruction executes normally.
- Self-overwrite: r1=7, ADD r1,r1,r1 -> r1=6 and result=6 after one execution; a second issue gives r1=4.
